// File: rtl/muldiv.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide
// with ready/valid handshakes and a single-cycle path for divide-by-zero and signed overflow.
module muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;     // product / quotient sign
  logic        rneg_q, rneg_d;   // remainder sign
  logic [31:0] mcand_q, mcand_d; // multiplicand magnitude or divisor magnitude
  logic [63:0] acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] y_q, y_d;

  // Operand decode at accept
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf;
  logic [31:0] special_y;

  always_comb begin
    a_signed  = (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
    b_signed  = (op == OpMulh) || (op == OpDiv) || (op == OpRem);
    a_neg     = a_signed & a[31];
    b_neg     = b_signed & b[31];
    a_mag     = a_neg ? (~a + 32'd1) : a;
    b_mag     = b_neg ? (~b + 32'd1) : b;
    div_zero  = op[2] && (b == 32'd0);
    div_ovf   = ((op == OpDiv) || (op == OpRem)) &&
                (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    special_y = 32'd0;
    if (div_zero) begin
      special_y = op[1] ? a : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      special_y = op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration of the shared datapath
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] iter_next;
  logic        unused_div_bit;

  always_comb begin
    mul_sum        = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    mul_next       = {mul_sum, acc_q[31:1]};
    div_shift      = {acc_q[63:32], acc_q[31]};
    div_diff       = {1'b0, div_shift} - {2'b00, mcand_q};
    unused_div_bit = div_diff[32];
    // Borrow means the trial subtraction is undone and a zero quotient bit shifts in.
    div_next       = div_diff[33] ? {acc_q[62:0], 1'b0}
                                  : {div_diff[31:0], acc_q[30:0], 1'b1};
    iter_next      = op_q[2] ? div_next : mul_next;
  end

  // Sign correction of the final iteration's result
  logic [63:0] prod_signed;
  logic [31:0] quo, rem;
  logic [31:0] calc_y;

  always_comb begin
    prod_signed = neg_q ? (~iter_next + 64'd1) : iter_next;
    quo         = iter_next[31:0];
    rem         = iter_next[63:32];
    calc_y      = 32'd0;
    unique case (op_q)
      OpMul:                    calc_y = prod_signed[31:0];
      OpMulh, OpMulhsu, OpMulhu: calc_y = prod_signed[63:32];
      OpDiv, OpDivu:            calc_y = neg_q ? (~quo + 32'd1) : quo;
      OpRem, OpRemu:            calc_y = rneg_q ? (~rem + 32'd1) : rem;
      default:                  calc_y = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    y_d     = y_q;

    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_d = op;
            if (div_zero || div_ovf) begin
              y_d     = special_y;
              state_d = StDone;
            end else begin
              cnt_d   = 5'd31;
              neg_d   = a_neg ^ b_neg;
              rneg_d  = a_neg;
              mcand_d = op[2] ? b_mag : a_mag;
              acc_d   = {32'd0, (op[2] ? a_mag : b_mag)};
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          acc_d = iter_next;
          if (cnt_q == 5'd0) begin
            y_d     = calc_y;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      op_q    <= 3'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      mcand_q <= 32'd0;
      acc_q   <= 64'd0;
      y_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign y         = y_q;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed vector table, random ops against an arithmetic
// reference model, and hand-written backpressure / flush / reset sequences.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, y;
  logic [2:0]  op;

  always #5 clk = ~clk;

  muldiv dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] z);
    logic signed [63:0] sx, sz, ux, uz, p;
    sx = {{32{x[31]}}, x};
    sz = {{32{z[31]}}, z};
    ux = {32'd0, x};
    uz = {32'd0, z};
    p  = 64'sd0;
    case (o)
      3'd0: begin p = ux * uz; return p[31:0]; end
      3'd1: begin p = sx * sz; return p[63:32]; end
      3'd2: begin p = sx * uz; return p[63:32]; end
      3'd3: begin p = ux * uz; return p[63:32]; end
      3'd4: begin
        if (z == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && z == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sx / sz; return p[31:0];
      end
      3'd5: begin if (z == 0) return 32'hFFFF_FFFF; return x / z; end
      3'd6: begin
        if (z == 0) return x;
        if (x == 32'h8000_0000 && z == 32'hFFFF_FFFF) return 32'd0;
        p = sx % sz; return p[31:0];
      end
      default: begin if (z == 0) return x; return x % z; end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] x,
                                     input logic [31:0] z);
    if (o[2] && z == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && z == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op from IDLE, wait (bounded) for the result, then consume it.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z,
                        output logic [31:0] yo, output int lat);
    a = x; b = z; op = o; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    yo = y;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] z;
    logic [31:0] ey;
    int          elat;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] ry, last_y;
  int          rl, hits;

  initial begin
    vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 33};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33};
    vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33};
    vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC, 33};
    vecs[7]  = '{3'd7, 32'hFFFF_FFF9, 32'h2, 32'h0000_0001, 33};
    vecs[8]  = '{3'd4, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'h1234, 32'h0, 32'h0000_1234, 1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 32'd0; b = 32'd0; op = 3'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_y", y, 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].o, vecs[i].x, vecs[i].z, ry, rl);
      chk($sformatf("vec%0d_y", i), ry, vecs[i].ey);
      chk($sformatf("vec%0d_latency", i), rl, vecs[i].elat);
      chk($sformatf("vec%0d_idle_after", i), {30'd0, in_ready, out_valid}, 32'h2);
    end

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  ro;
      logic [31:0] rx, rz;
      int          sel;
      ro  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      rx  = $urandom;
      rz  = $urandom;
      if (sel == 0) rz = 32'd0;
      else if (sel == 1) begin rx = 32'h8000_0000; rz = 32'hFFFF_FFFF; end
      else if (sel == 2) begin rx = 32'($urandom_range(0, 40)); rz = 32'($urandom_range(1, 9)); end
      else if (sel == 3) rz = rz | 32'h8000_0000;
      run_op(ro, rx, rz, ry, rl);
      chk($sformatf("rand%0d op%0d a=%h b=%h y", i, ro, rx, rz), ry, model(ro, rx, rz));
      chk($sformatf("rand%0d latency", i), rl, exp_latency(ro, rx, rz));
    end

    // Backpressure: result held, in_valid ignored, next accept one cycle after consume
    a = 32'd7; b = 32'd9; op = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; op = 3'd3;
    rl = 0;
    while (!out_valid && rl < 60) begin @(posedge clk); #1; rl++; end
    chk("bp_first_y", y, 32'd63);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_y", i), y, 32'd63);
      chk($sformatf("bp_hold%0d_flags", i), {30'd0, in_ready, out_valid}, 32'h1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_after_consume", {30'd0, in_ready, out_valid}, 32'h2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_accepted", {31'd0, in_ready}, 32'd0);
    rl = 1;
    while (!out_valid && rl < 60) begin @(posedge clk); #1; rl++; end
    chk("bp_second_latency", rl, 32'd33);
    chk("bp_second_y", y, model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    last_y = model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Flush at CALC cycle 15
    a = 32'h1234_5678; b = 32'h9ABC_DEF0; op = 3'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", {30'd0, in_ready, out_valid}, 32'h2);
    chk("flush_y_kept", y, last_y);
    // flush and in_valid together in IDLE: nothing accepted
    a = 32'd3; b = 32'd0; op = 3'd4; flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_vs_accept", {30'd0, in_ready, out_valid}, 32'h2);
    hits = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) hits++; end
    chk("flush_no_result", hits, 32'd0);
    run_op(3'd0, 32'd3, 32'd5, ry, rl);
    chk("flush_then_mul_y", ry, 32'h0000_000F);
    chk("flush_then_mul_latency", rl, 32'd33);

    // Reset at CALC cycle 20
    a = 32'hDEAD_BEEF; b = 32'h0000_0013; op = 3'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_mid_idle", {30'd0, in_ready, out_valid}, 32'h2);
    chk("reset_mid_y", y, 32'd0);
    hits = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) hits++; end
    chk("reset_no_result", hits, 32'd0);
    run_op(3'd0, 32'd3, 32'd5, ry, rl);
    chk("reset_then_mul_y", ry, 32'h0000_000F);
    chk("reset_then_mul_latency", rl, 32'd33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv.md
# muldiv

Iterative RV32M multiply/divide unit that sits beside the combinational ALU in the execute stage. It implements all eight M-extension operations with a ready/valid handshake on both the operand and result sides. Each operation is a 32-iteration shift-add multiply or restoring divide, and the pipeline stalls on it. Division by zero and signed overflow take a single-cycle fast path.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  synchronous kill of any in-flight operation
- in_valid  input  1  operands/op present
- in_ready  output  1  unit can accept (high only in IDLE)
- a  input  32  rs1 operand
- b  input  32  rs2 operand
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- out_valid  output  1  y holds a result
- out_ready  input  1  consumer takes result
- y  output  32  result

## Operation
- States: IDLE, CALC, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- Accept: in_valid && in_ready at a rising edge latches a, b, op and goes IDLE→CALC with iteration counter = 31.
- Signedness:
  - a is signed for MULH, MULHSU, DIV, REM.
  - b is signed for MULH, DIV, REM.
  - MUL's low word is sign-agnostic.
  - Signed operands are converted to magnitudes at accept; result sign is recorded.
- Multiply: 64-bit shift-add over 32 iterations, one multiplier bit per cycle.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
  - The 64-bit product is negated before selection when the result sign is negative.
- Divide: restoring, one quotient bit per cycle.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Signs are applied on the CALC→DONE edge.
- Special cases: detected at accept; the unit goes IDLE→DONE directly with y loaded.
  - b==0, DIV/DIVU: y=32'hFFFFFFFF.
  - b==0, REM/REMU: y=a.
  - a==32'h80000000, b==32'hFFFFFFFF, DIV: y=32'h80000000.
  - Same operands, REM: y=0.
- CALC: the counter decrements each cycle. At the edge where the counter reaches 0, the final iteration is applied, the signed-corrected result is registered into y, and the state goes CALC→DONE.
- DONE: y and out_valid hold stable until out_ready is high at an edge; the state then goes DONE→IDLE.
- Priority, highest first:
  - reset: all state cleared.
  - flush: the state goes to IDLE from any state, a result in DONE is discarded, and y is unchanged.
  - Normal transitions.
- in_valid in CALC or DONE is ignored; no input is latched.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, y=0, counter=0, all internal accumulators 0.
- Normal latency, where acceptance edge = E0:
  - The counter runs for 32 CALC cycles; CALC→DONE happens at E32.
  - out_valid is high from the cycle after E32, i.e. 33 cycles after the acceptance cycle.
- Special-case latency: out_valid is high in the cycle immediately after the acceptance cycle.
- Back-to-back:
  - A result consumed at edge Ek returns the unit to IDLE; in_ready is high in cycle k+1.
  - The next accept is at edge E(k+1) at earliest.
  - Minimum spacing between normal operations is 34 cycles.
- in_ready and out_valid depend only on registered state; there are no combinational input→output paths.
- Reset or flush asserted mid-CALC: the unit is in IDLE the following cycle with in_ready=1 and out_valid=0. No result is produced for the killed operation.
- flush and in_valid in the same IDLE cycle: flush wins and nothing is accepted.

## Test plan
- Reset:
  - Stimulus: reset high for 2 cycles, then low.
  - Required: in_ready=1, out_valid=0, y=0.
- Signed/unsigned multiply:
  - Stimulus: a=32'hFFFFFFFF, b=32'h00000002, each of MUL, MULH, MULHSU, MULHU.
  - Required: y=FFFFFFFE, FFFFFFFF, FFFFFFFF, 00000001 respectively.
  - Each result asserts out_valid exactly 33 cycles after acceptance.
- Signed divide/remainder:
  - Stimulus: a=-7 (FFFFFFF9), b=2.
  - Required: DIV→FFFFFFFD (-3), REM→FFFFFFFF (-1), DIVU→7FFFFFFC, REMU→00000001.
- Special cases:
  - Stimulus: a=0x1234, b=0 (DIV, REM); a=80000000, b=FFFFFFFF (DIV, REM).
  - Required: y=FFFFFFFF, 00001234, 80000000, 00000000.
  - out_valid is asserted the cycle after acceptance.
- Handshake backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid rises, and drive in_valid throughout.
  - Required: y stable, in_ready=0, no new operation accepted.
  - Release out_ready; the next operation is accepted one cycle later.
- Flush/reset mid-operation:
  - Stimulus: flush at CALC cycle 15, and separately reset at CALC cycle 20.
  - Required: IDLE next cycle, out_valid never asserted for the killed operation.
  - A subsequent MUL 3×5 returns 0000000F.
